// File: rtl/calculator_pkg.sv
// Shared types and constants for the calculator sequencing controller.
// Opcodes, FSM states and the single-cycle ALU helper.
package calculator_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    localparam logic [DATA_W-1:0] DIV0_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ITER,
        S_DONE
    } state_t;

    function automatic logic [DATA_W-1:0] alu(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  r = a << b[4:0];
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/calculator_debounce.sv
// Start button conditioning: 2-FF synchronizer, stability counter
// and a registered one-cycle pulse on the clean rising edge.
module calculator_debounce #(
    parameter int DEBOUNCE_CYCLES = 20_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic start_p
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          clean;
    logic          clean_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            clean   <= 1'b0;
            clean_d <= 1'b0;
            cnt     <= '0;
            start_p <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            clean_d <= clean;
            start_p <= clean & ~clean_d;
            // Any sample agreeing with the clean level restarts the count.
            if (sync2 != clean) begin
                if (cnt == CNT_LAST) begin
                    clean <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/calculator_ctrl.sv
// Calculator sequencer: latches operands on a debounced start, runs
// ALU ops in one cycle and mul/div one bit per cycle over 32 cycles.
module calculator_ctrl
    import calculator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_start,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] cal_result,
    output logic              disp_load,
    output logic              busy,
    output logic              err
);

    logic start_p;

    calculator_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_start),
        .start_p(start_p)
    );

    state_t            state;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        op_q;
    logic [4:0]        cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] rem;

    logic [DATA_W-1:0] acc_n;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   rem_sub;
    logic              q_bit;
    logic [DATA_W-1:0] rem_n;
    logic [DATA_W-1:0] quo_n;

    // a_q doubles as multiplicand (shifting left) and as the dividend
    // that shifts out MSB-first while quotient bits enter at the LSB.
    always_comb begin
        acc_n   = acc + (b_q[0] ? a_q : '0);
        rem_sh  = {rem, a_q[DATA_W-1]};
        rem_sub = rem_sh - {1'b0, b_q};
        q_bit   = ~rem_sub[DATA_W];
        rem_n   = q_bit ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        quo_n   = {a_q[DATA_W-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            cnt        <= '0;
            acc        <= '0;
            rem        <= '0;
            cal_result <= '0;
            disp_load  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            disp_load <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_p) begin
                        a_q  <= operand_a;
                        b_q  <= operand_b;
                        op_q <= op;
                        acc  <= '0;
                        rem  <= '0;
                        cnt  <= 5'd31;
                        busy <= 1'b1;
                        err  <= 1'b0;
                        if (op == OP_DIV && operand_b == '0) begin
                            err        <= 1'b1;
                            cal_result <= DIV0_RESULT;
                            disp_load  <= 1'b1;
                            state      <= S_DONE;
                        end else if (op == OP_MUL || op == OP_DIV) begin
                            state <= S_ITER;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    cal_result <= alu(op_q, a_q, b_q);
                    disp_load  <= 1'b1;
                    state      <= S_DONE;
                end
                S_ITER: begin
                    if (op_q == OP_MUL) begin
                        acc <= acc_n;
                        a_q <= a_q << 1;
                        b_q <= b_q >> 1;
                    end else begin
                        rem <= rem_n;
                        a_q <= quo_n;
                    end
                    if (cnt == '0) begin
                        cal_result <= (op_q == OP_MUL) ? acc_n : quo_n;
                        disp_load  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calculator_ctrl.sv
// Bench for calculator_ctrl: vector table, corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_calculator_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [2:0]  op = '0;
    logic [31:0] cal_result;
    logic        disp_load;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    calculator_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .op        (op),
        .cal_result(cal_result),
        .disp_load (disp_load),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_load;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (o)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return p[31:0];
            default: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        endcase
    endfunction

    // Raw press is set in cycle 0; clean start pulse lands in cycle 7.
    function automatic int model_load(input logic [2:0] o,
                                      input logic [31:0] b);
        if (o == 3'd7 && b == 0) return 8;
        if (o >= 3'd6) return 40;
        return 9;
    endfunction

    // scen: 0 press, 1 bounce, 2 glitch, 3 re-press while busy, 4 reset
    function automatic logic btn_pat(input int scen, input int cyc);
        case (scen)
            1: return (cyc < 20) ? ((cyc / 2) % 2 == 0) : (cyc < 50);
            2: return (cyc >= 5 && cyc < 8);
            3: return (cyc < 10) || (cyc >= 20 && cyc < 50);
            4: return (cyc < 10);
            default: return (cyc < 50);
        endcase
    endfunction

    task automatic run_case(
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic [2:0]  o,
        input  int          scen,
        output int          t_busy,
        output int          t_load,
        output int          n_load,
        output int          n_busy,
        output logic [31:0] res,
        output logic        err_b,
        output logic        err_l
    );
        t_busy = -1;
        t_load = -1;
        n_load = 0;
        n_busy = 0;
        res    = 'x;
        err_b  = 'x;
        err_l  = 'x;
        @(negedge clk);
        operand_a = a;
        operand_b = b;
        op        = o;
        btn_start = btn_pat(scen, 0);
        for (int cyc = 1; cyc < 70; cyc++) begin
            @(negedge clk);
            if (busy) begin
                n_busy++;
                if (t_busy < 0) begin
                    t_busy = cyc;
                    err_b  = err;
                end
            end
            if (disp_load) begin
                n_load++;
                if (t_load < 0) begin
                    t_load = cyc;
                    res    = cal_result;
                    err_l  = err;
                end
            end
            if (scen == 4 && cyc == 18) begin
                chk("rst_mid result", cal_result, 32'd0);
                chk("rst_mid busy", 32'(busy), 32'd0);
                chk("rst_mid load", 32'(disp_load), 32'd0);
                chk("rst_mid err", 32'(err), 32'd0);
            end
            btn_start = btn_pat(scen, cyc);
            rst = (scen == 4 && cyc == 17);
            if (scen == 3 && cyc == 12) begin
                operand_a = $urandom;
                operand_b = $urandom;
                op        = 3'($urandom_range(0, 7));
            end
        end
        btn_start = 1'b0;
        rst       = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_vec(input string tag, input vec_t v,
                             input int scen);
        int t_busy, t_load, n_load, n_busy;
        logic [31:0] res;
        logic err_b, err_l;
        run_case(v.a, v.b, v.op, scen, t_busy, t_load, n_load, n_busy,
                 res, err_b, err_l);
        chk({tag, " result"}, res, v.exp_res);
        chk({tag, " err_at_load"}, 32'(err_l), 32'(v.exp_err));
        chk({tag, " err_at_latch"}, 32'(err_b), 32'(v.exp_err));
        chk({tag, " load_cycle"}, 32'(t_load), 32'(v.exp_load));
        chk({tag, " load_count"}, 32'(n_load), 32'd1);
        chk({tag, " busy_start"}, 32'(t_busy), 32'd8);
        chk({tag, " busy_len"}, 32'(n_busy), 32'(v.exp_load - 7));
    endtask

    initial begin
        int t_busy, t_load, n_load, n_busy;
        logic [31:0] res;
        logic err_b, err_l;
        vec_t v;

        tbl[0] = '{32'hFFFF_FFFF, 32'd2, 3'd0, 32'd1, 1'b0, 9};
        tbl[1] = '{32'h0001_0000, 32'h0003_0001, 3'd6,
                   32'h0001_0000, 1'b0, 40};
        tbl[2] = '{32'd100, 32'd7, 3'd7, 32'd14, 1'b0, 40};
        tbl[3] = '{32'd100, 32'd0, 3'd7, 32'hFFFF_FFFF, 1'b1, 8};
        tbl[4] = '{32'd5, 32'd7, 3'd1, 32'hFFFF_FFFE, 1'b0, 9};
        tbl[5] = '{32'd1, 32'd35, 3'd5, 32'd8, 1'b0, 9};
        tbl[6] = '{32'hA5A5_0000, 32'h0F0F_F0F0, 3'd4,
                   32'hAAAA_F0F0, 1'b0, 9};
        tbl[7] = '{32'hFFFF_FFFF, 32'd1, 3'd7, 32'hFFFF_FFFF, 1'b0, 40};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset result", cal_result, 32'd0);
        chk("reset load", 32'(disp_load), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++)
            check_vec($sformatf("vec%0d", i), tbl[i], 0);

        v = '{32'd3, 32'd4, 3'd0, 32'd7, 1'b0, 29};
        run_case(v.a, v.b, v.op, 1, t_busy, t_load, n_load, n_busy,
                 res, err_b, err_l);
        chk("bounce load_count", 32'(n_load), 32'd1);
        chk("bounce load_cycle", 32'(t_load), 32'(v.exp_load));
        chk("bounce result", res, v.exp_res);

        run_case(32'd9, 32'd9, 3'd0, 2, t_busy, t_load, n_load, n_busy,
                 res, err_b, err_l);
        chk("glitch load_count", 32'(n_load), 32'd0);
        chk("glitch busy", 32'(n_busy), 32'd0);

        check_vec("busy_repress", tbl[1], 3);

        run_case(32'd100, 32'd7, 3'd7, 4, t_busy, t_load, n_load, n_busy,
                 res, err_b, err_l);
        chk("rst_mid load_count", 32'(n_load), 32'd0);

        check_vec("after_rst", tbl[0], 0);

        for (int i = 0; i < 24; i++) begin
            v.op = 3'($urandom_range(0, 7));
            v.a  = $urandom;
            case ($urandom_range(0, 3))
                0: v.b = 32'd0;
                1: v.b = 32'($urandom_range(1, 1000));
                default: v.b = $urandom;
            endcase
            v.exp_res  = model(v.op, v.a, v.b);
            v.exp_err  = (v.op == 3'd7 && v.b == 0);
            v.exp_load = model_load(v.op, v.b);
            check_vec($sformatf("rand%0d", i), v, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calculator_ctrl.md
# calculator_ctrl

Sequencing controller for the calculator datapath. Debounces the front-panel start button, latches two 32-bit operands and an opcode, then runs the selected operation: single-cycle ALU ops, or 32-iteration shift-add multiply and restoring divide. It delivers the result on `cal_result` with a one-cycle `disp_load` strobe that drives the `button` input of `calculator_display`.

## Interface
- `DEBOUNCE_CYCLES`, default 20_000: consecutive stable samples required before the clean button level changes.
- `clk  in  1`: system clock.
- `rst  in  1`: reset, synchronous, active-high. Applies to all state, including debounce.
- `btn_start  in  1`: raw, asynchronous, bouncing start button.
- `operand_a  in  32`: first operand, unsigned. Sampled only at latch.
- `operand_b  in  32`: second operand, unsigned. Sampled only at latch.
- `op  in  3`: opcode. Sampled only at latch.
- `cal_result  out  32`: registered result. Holds until the next completion.
- `disp_load  out  1`: one-cycle pulse in the cycle `cal_result` first carries a new value.
- `busy  out  1`: high from the latch cycle +1 until the `disp_load` cycle, inclusive.
- `err  out  1`: sticky divide-by-zero flag. Cleared at the next latch.

## Operation
- Opcodes:
  - 000 add (mod 2^32)
  - 001 sub a−b (mod 2^32)
  - 010 and
  - 011 or
  - 100 xor
  - 101 shl a by b[4:0]
  - 110 mul: low 32 bits of unsigned product
  - 111 div: unsigned quotient a/b
- Button path:
  - 2-FF synchronizer, then the debouncer.
  - Clean level changes only after the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - A rising edge of the clean level gives a one-cycle `start_p`.
- FSM states: IDLE, EXEC, ITER, DONE.
- IDLE, `start_p`=1:
  - Latch operands and op. Clear `err`.
  - div with b==0: set `err`, go to DONE.
  - mul/div otherwise: load iteration counter with 31, go to ITER.
  - Any other op: go to EXEC.
- IDLE, no `start_p`: stay.
- EXEC: compute the single-cycle result into the result register, go to DONE.
- ITER:
  - One bit per cycle. mul: multiplier LSB-first. div: restoring, quotient MSB-first, 33-bit partial remainder.
  - Counter==0: go to DONE. Otherwise decrement.
- DONE:
  - Drive `cal_result` from the result register (or 32'hFFFF_FFFF on div-by-zero). Assert `disp_load`.
  - Return to IDLE.
- `start_p` outside IDLE is discarded, not queued.
- Reset values:
  - `cal_result`=0, `disp_load`=0, `busy`=0, `err`=0.
  - State IDLE, clean button level 0, debounce counter 0.
- Reset mid-operation aborts. No `disp_load` is produced for the aborted op.
- Button held across completion produces no second start; a new rising clean edge is required.

## Timing
- Let L be the cycle `start_p` is high in IDLE. Operands are sampled at the L clock edge.
- Single-cycle ops: EXEC at L+1, DONE at L+2, so `disp_load` and new `cal_result` appear at L+2.
- mul/div: ITER at L+1..L+32, DONE at L+33, `disp_load` at L+33.
- Div-by-zero: DONE at L+1, `disp_load` and `err` at L+1.
- `busy` is high from L+1 through the `disp_load` cycle.
- A new start is accepted no earlier than the cycle after DONE.
- Raw press to `start_p`: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles, for a clean input.

## Structure
- Shared package `calculator_pkg`:
  - `DATA_W`=32
  - opcode localparams (OP_ADD … OP_DIV)
  - FSM state enum
  - `DIV0_RESULT`=32'hFFFF_FFFF
- Sub-module `calculator_debounce`:
  - Contains the synchronizer, the debounce counter and the rising-edge pulse.
  - Parameterized by `DEBOUNCE_CYCLES`, reset by `rst`.
- Datapath (ALU, mul/div iteration registers) and FSM live in `calculator_ctrl`.

## Test plan
Run with `DEBOUNCE_CYCLES`=4.
- **Add wrap:** a=32'hFFFF_FFFF, b=2, op=000, clean press. Expect `cal_result`=1, `disp_load` once at L+2, `err`=0.
- **Multiply:** a=32'h0001_0000, b=32'h0003_0001, op=110. Expect `cal_result`=32'h0001_0000 (low word) at exactly L+33, `busy` high for 33 cycles.
- **Divide:** a=100, b=7, op=111. Expect `cal_result`=14 at L+33. Repeat with b=0: expect `cal_result`=32'hFFFF_FFFF and `err`=1 at L+1, with `err` clearing at the next latch.
- **Bounce:** raw button toggling every 2 cycles for 20 cycles, then held high. Expect exactly one `start_p` and one `disp_load`; a glitch shorter than 4 cycles produces none.
- **Start while busy:** second clean press during ITER of a mul. Expect it ignored, only one `disp_load`, and the result unaffected by operand changes after L.
- **Reset mid-ITER:** `rst` at L+10 for 1 cycle. Expect all outputs at reset values next cycle, no `disp_load`, and the next press to work normally.
